// File: rtl/nanov_alu_pkg.sv
// ----------------------------------------------------------------------------
// nanov_alu_pkg
// Shared definitions for the nanoV digit-serial ALU.
//   - ALU op encodings (4-bit codes presented on the op port with start)
//   - FSM state enum used by the top level
//   - small decode helpers shared by the top level and the digit slice
// Configuration macro: NANOV_ALU_ZBB_EN. It enables ANDN/ORN/XNOR in
// nanov_alu_digit; the encodings are always declared here.
// ----------------------------------------------------------------------------
package nanov_alu_pkg;

  // Op encodings. Bit 3 marks "invert B" for subtract and for the Zbb
  // logic variants. Bit 2 marks the logic class.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ANDN = 4'b1111;
  localparam logic [3:0] ALU_ORN  = 4'b1110;
  localparam logic [3:0] ALU_XNOR = 4'b1100;

  // Sequencer states: IDLE waits for start, RUN consumes digits 1..N-1.
  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } alu_state_e;

  // Logic class: op[2] set, with op[1:0] selecting AND/OR/XOR.
  // Code pattern x101 has no logic meaning and is treated as undefined.
  function automatic logic isLogicOp(input logic [3:0] opCode);
    return opCode[2] && (opCode[1:0] != 2'b01);
  endfunction

  function automatic logic isAddSub(input logic [3:0] opCode);
    return (opCode == ALU_ADD) || (opCode == ALU_SUB);
  endfunction

  function automatic logic isCmpOp(input logic [3:0] opCode);
    return (opCode == ALU_SLT) || (opCode == ALU_SLTU);
  endfunction

  // B inversion for the adder. Defined codes follow op[3]|op[1]. Undefined
  // codes force a subtract so their lt/eq flags behave exactly like SUB.
  function automatic logic aluBinv(input logic [3:0] opCode);
    if (isAddSub(opCode) || isCmpOp(opCode) || isLogicOp(opCode)) begin
      return opCode[3] | opCode[1];
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/nanov_alu_digit.sv
// ----------------------------------------------------------------------------
// nanov_alu_digit
// Purely combinational DW-bit slice of the serial ALU. It computes one
// result digit, the carry out of the digit adder, and the candidate
// less-than flag that applies when this digit is the final (MSB) digit.
//
// Ports
//   op    in   4    op code in effect for this digit
//   a     in   DW   operand A digit
//   b     in   DW   operand B digit
//   cin   in   1    carry into this digit
//   d     out  DW   result digit (sum, logic result, or zero)
//   cout  out  1    carry out of the DW+1-bit digit sum
//   lts   out  1    lt flag if this is the final digit
//   zero  out  1    the value that feeds the eq accumulation is zero
//
// Configuration macro: NANOV_ALU_ZBB_EN
//   defined   : for logic codes, op[3] inverts b (ANDN/ORN/XNOR)
//   undefined : op[3] is ignored for logic codes
// ----------------------------------------------------------------------------
module nanov_alu_digit
  import nanov_alu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] d,
  output logic          cout,
  output logic          lts,
  output logic          zero
);

  logic          binv;
  logic [DW-1:0] bArith;
  logic [DW-1:0] bLogic;
  logic [DW-1:0] logicRes;
  logic [DW:0]   sum;

  // Digit adder plus logic unit. The adder always runs, even for logic ops,
  // because compare flags and undefined codes are derived from it. The
  // extra MSB of the sum is the carry chained into the next digit.
  always_comb begin
    binv   = aluBinv(op);
    bArith = binv ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bArith} + {{DW{1'b0}}, cin};
    cout   = sum[DW];

`ifdef NANOV_ALU_ZBB_EN
    bLogic = op[3] ? ~b : b;
`else
    bLogic = b;
`endif

    case (op[1:0])
      2'b11:   logicRes = a & bLogic;
      2'b10:   logicRes = a | bLogic;
      default: logicRes = a ^ bLogic;
    endcase

    // Compares drive zeros on d; the core reads lt instead.
    if (isLogicOp(op)) begin
      d = logicRes;
    end else if (isAddSub(op)) begin
      d = sum[DW-1:0];
    end else begin
      d = '0;
    end

    // eq tracks the logic result for logic ops and the adder output
    // otherwise, which makes SLT/SLTU/undefined report a == b like SUB.
    zero = isLogicOp(op) ? (logicRes == '0) : (sum[DW-1:0] == '0);

    // Unsigned: borrow means a < b. Signed: N ^ V collapses to
    // a_msb ^ b'_msb ^ carry_out.
    if (op == ALU_SLTU) begin
      lts = ~sum[DW];
    end else begin
      lts = a[DW-1] ^ bArith[DW-1] ^ sum[DW];
    end
  end

endmodule

// File: rtl/nanov_alu_serial.sv
// ----------------------------------------------------------------------------
// nanov_alu_serial
// Digit-serial ALU for the nanoV core. Operands arrive LSB digit first, DW
// bits per cycle, for N = XLEN/DW back-to-back cycles. Carry, digit count and
// zero accumulation are kept here; the result stream and flags are registered.
//
// Ports
//   clk      in   1    core clock
//   rstn     in   1    asynchronous active-low reset
//   start    in   1    digit 0 of a new op is on a/b; latches op
//   op       in   4    ALU op, sampled only with start
//   a        in   DW   operand A digit
//   b        in   DW   operand B digit
//   d        out  DW   registered result digit
//   d_valid  out  1    d holds a valid digit
//   done     out  1    pulse with the final valid digit
//   lt       out  1    compare result, held from done to the next done
//   eq       out  1    whole result zero, held from done to the next done
//   busy     out  1    digits 1..N-1 of the current op still expected
//
// Configuration macro: NANOV_ALU_ZBB_EN (handled in nanov_alu_digit).
// ----------------------------------------------------------------------------
module nanov_alu_serial
  import nanov_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DW   = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] d,
  output logic          d_valid,
  output logic          done,
  output logic          lt,
  output logic          eq,
  output logic          busy
);

  localparam int N  = XLEN / DW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  alu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op_q;
  logic          cy_q;
  logic          zacc_q;

  logic [3:0]    opCur;
  logic          cinCur;
  logic          digitActive;
  logic          lastDigit;
  logic          zeroAll_d;

  logic [DW-1:0] digitD;
  logic          digitCout;
  logic          digitLt;
  logic          digitZero;

  // Current-digit control. On a start cycle the live op port applies and
  // carry-in is the B-inversion bit; afterwards the latched op and the
  // chained carry take over. A start overrides any op in flight, which is
  // how an abort simply becomes a fresh op.
  always_comb begin
    opCur       = start ? op : op_q;
    cinCur      = start ? aluBinv(op) : cy_q;
    digitActive = start || (state_q == ST_RUN);
    if (start) begin
      lastDigit = (N == 1);
    end else begin
      lastDigit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    end
    zeroAll_d = (start ? 1'b1 : zacc_q) & digitZero;
  end

  nanov_alu_digit #(
    .DW(DW)
  ) u_digit (
    .op  (opCur),
    .a   (a),
    .b   (b),
    .cin (cinCur),
    .d   (digitD),
    .cout(digitCout),
    .lts (digitLt),
    .zero(digitZero)
  );

  // Sequencer, carry/zero accumulators and all registered outputs. The
  // counter holds the index of the digit expected next, so it is 1 right
  // after start and the op ends when digit N-1 is consumed. lt/eq only move
  // on the final digit, so they stay stable while the next op streams.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b1;
      d       <= '0;
      d_valid <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      busy    <= 1'b0;
    end else begin
      d       <= digitActive ? digitD : '0;
      d_valid <= digitActive;
      done    <= lastDigit;

      if (digitActive) begin
        cy_q   <= digitCout;
        zacc_q <= zeroAll_d;
      end

      if (lastDigit) begin
        lt <= digitLt;
        eq <= zeroAll_d;
      end

      if (start) begin
        op_q    <= op;
        cnt_q   <= CW'(1);
        state_q <= (N > 1) ? ST_RUN : ST_IDLE;
        busy    <= (N > 1);
      end else if (state_q == ST_RUN) begin
        if (cnt_q == CNT_LAST) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy    <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nanov_alu_serial.sv
// ----------------------------------------------------------------------------
// tb_nanov_alu_serial
// Self-checking bench for nanov_alu_serial. Four DUT copies (DW = 4, 1, 2, 8)
// share one operand bus; only one is started at a time. A collector
// reassembles each result stream and compares it against expectations that
// were queued when the stimulus was driven.
// Honours NANOV_ALU_ZBB_EN when forming expectations for the Zbb codes.
// ----------------------------------------------------------------------------
module tb_nanov_alu_serial;
  import nanov_alu_pkg::*;

  localparam int XLEN = 32;
  localparam int NI   = 4;

`ifdef NANOV_ALU_ZBB_EN
  localparam logic [31:0] ANDN_EXP = 32'hF000_F000;
  localparam logic [31:0] XNOR_EXP = 32'hFFFF_FFFF;
  localparam logic        XNOR_EQ  = 1'b0;
`else
  localparam logic [31:0] ANDN_EXP = 32'h0F00_0F00;
  localparam logic [31:0] XNOR_EXP = 32'h0000_0000;
  localparam logic        XNOR_EQ  = 1'b1;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        chkLt;
    logic        lt;
    logic        chkEq;
    logic        eq;
  } vec_t;

  typedef struct {
    int          inst;
    logic [31:0] res;
    int          nValid;
    logic        chkLt;
    logic        lt;
    logic        chkEq;
    logic        eq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NI-1:0] startV;
  logic [3:0]    opB;
  logic [7:0]    aB;
  logic [7:0]    bB;
  wire  [7:0]    dV [NI];
  wire  [NI-1:0] dValidV;
  wire  [NI-1:0] doneV;
  wire  [NI-1:0] ltV;
  wire  [NI-1:0] eqV;
  wire  [NI-1:0] busyV;

  exp_t        sbQ[$];
  logic [31:0] acc [NI];
  int          dig [NI];
  int          nTests = 0;
  int          nFail  = 0;
  vec_t        vecs [16];

  always #5 clk = ~clk;

  function automatic int dwOf(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int W = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    wire [W-1:0] dOut;
    nanov_alu_serial #(.XLEN(XLEN), .DW(W)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (startV[g]),
      .op     (opB),
      .a      (aB[W-1:0]),
      .b      (bB[W-1:0]),
      .d      (dOut),
      .d_valid(dValidV[g]),
      .done   (doneV[g]),
      .lt     (ltV[g]),
      .eq     (eqV[g]),
      .busy   (busyV[g])
    );
    assign dV[g] = 8'(dOut);
  end

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    nTests++;
    if (got !== want) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Golden model built from whole-word arithmetic.
  function automatic exp_t refModel(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] bl;
    e.inst   = i;
    e.nValid = XLEN / dwOf(i);
    e.chkLt  = 1'b0;
    e.lt     = 1'b0;
    e.chkEq  = 1'b1;
    bl = b;
`ifdef NANOV_ALU_ZBB_EN
    if (op[3]) bl = ~b;
`endif
    case (op)
      ALU_ADD: begin e.res = a + b; e.eq = ((a + b) == 32'd0); end
      ALU_SUB: begin e.res = a - b; e.eq = (a == b); end
      ALU_SLT: begin e.res = 32'd0; e.chkLt = 1'b1; e.lt = ($signed(a) < $signed(b)); e.eq = (a == b); end
      ALU_SLTU: begin e.res = 32'd0; e.chkLt = 1'b1; e.lt = (a < b); e.eq = (a == b); end
      ALU_AND, ALU_ANDN: begin e.res = a & bl; e.eq = (e.res == 32'd0); end
      ALU_OR, ALU_ORN: begin e.res = a | bl; e.eq = (e.res == 32'd0); end
      default: begin e.res = a ^ bl; e.eq = (e.res == 32'd0); end
    endcase
    return e;
  endfunction

  task automatic pushExp(input int i, input logic [31:0] res, input int nValid,
                         input logic chkLt, input logic lt, input logic chkEq, input logic eq);
    exp_t e;
    e.inst = i; e.res = res; e.nValid = nValid;
    e.chkLt = chkLt; e.lt = lt; e.chkEq = chkEq; e.eq = eq;
    sbQ.push_back(e);
  endtask

  // Drives nDrive digits starting with start=1. Non-start cycles carry a
  // random op to show the latched op is what counts. Entered and left at
  // 1 time unit after a rising edge, leaving start low.
  task automatic applyStimulus(input int i, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int nDrive);
    int w;
    logic [31:0] mask;
    w = dwOf(i);
    mask = (32'd1 << w) - 32'd1;
    for (int k = 0; k < nDrive; k++) begin
      startV    = '0;
      startV[i] = (k == 0);
      opB       = (k == 0) ? op : 4'($urandom);
      aB        = 8'((a >> (k * w)) & mask);
      bB        = 8'((b >> (k * w)) & mask);
      @(posedge clk);
      #1;
    end
    startV = '0;
  endtask

  // Called from the collector when done is seen on instance i.
  task automatic checkOutput(input int i);
    exp_t e;
    checkValue("done_with_dvalid", 32'(dValidV[i]), 32'd1);
    nTests++;
    if (sbQ.size() == 0) begin
      nFail++;
      $display("[TB] FAIL unexpected_done: got done on inst %0d, want no op pending", i);
      return;
    end
    e = sbQ.pop_front();
    checkValue("done_inst", 32'(i), 32'(e.inst));
    checkValue("result", acc[i], e.res);
    checkValue("dvalid_count", 32'(dig[i]), 32'(e.nValid));
    if (e.chkLt) checkValue("lt", 32'(ltV[i]), 32'(e.lt));
    if (e.chkEq) checkValue("eq", 32'(eqV[i]), 32'(e.eq));
  endtask

  task automatic checkReset(input int i);
    checkValue("rst_d", 32'(dV[i]), 32'd0);
    checkValue("rst_dvalid", 32'(dValidV[i]), 32'd0);
    checkValue("rst_done", 32'(doneV[i]), 32'd0);
    checkValue("rst_lt", 32'(ltV[i]), 32'd0);
    checkValue("rst_eq", 32'(eqV[i]), 32'd0);
    checkValue("rst_busy", 32'(busyV[i]), 32'd0);
  endtask

  // Bounded wait for every queued op to complete.
  task automatic waitIdle();
    int t;
    t = 0;
    while (sbQ.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    nTests++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL op_timeout: got %0d ops pending, want 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  // Collector: shift each valid digit in from the top so that after N digits
  // acc holds the most recent full result, then check on done.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NI; i++) dig[i] = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (dValidV[i]) begin
          acc[i] = (acc[i] >> dwOf(i)) | ({24'd0, dV[i]} << (XLEN - dwOf(i)));
          dig[i]++;
        end
        if (doneV[i]) begin
          checkOutput(i);
          dig[i] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  opList [10];
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t        e;

    opList = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
               ALU_ANDN, ALU_ORN, ALU_XNOR};

    vecs[0]  = '{ALU_ADD,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{ALU_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{ALU_ADD,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{ALU_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{ALU_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{ALU_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{ALU_ANDN, 32'hFF00_FF00, 32'h0F0F_0F0F, ANDN_EXP,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{ALU_XNOR, 32'h0000_0000, 32'h0000_0000, XNOR_EXP,      1'b0, 1'b0, 1'b1, XNOR_EQ};
    vecs[15] = '{ALU_SLTU, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

    rstn   = 1'b0;
    startV = '0;
    opB    = '0;
    aB     = '0;
    bB     = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) checkReset(i);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors on the DW=4 copy, streamed back to back.
    for (int v = 0; v < 16; v++) begin
      pushExp(0, vecs[v].res, 8, vecs[v].chkLt, vecs[v].lt, vecs[v].chkEq, vecs[v].eq);
      applyStimulus(0, vecs[v].op, vecs[v].a, vecs[v].b, 8);
    end
    waitIdle();
    checkValue("busy_after_table", 32'(busyV[0]), 32'd0);

    // Abort: ADD interrupted by a fresh XOR at digit 3; one done only.
    pushExp(0, 32'hF0F0_F0F0, 11, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, ALU_ADD, 32'h1111_1111, 32'h2222_2222, 3);
    checkValue("busy_mid_op", 32'(busyV[0]), 32'd1);
    applyStimulus(0, ALU_XOR, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 8);
    waitIdle();
    checkValue("busy_after_abort", 32'(busyV[0]), 32'd0);

    // Reset mid-op: set eq first so clearing it is visible, then reset
    // asynchronously while digit 5 is due, then run a clean op.
    pushExp(0, 32'h0000_0000, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, ALU_SUB, 32'h0000_0005, 32'h0000_0005, 8);
    waitIdle();
    applyStimulus(0, ALU_ADD, 32'h1234_5678, 32'h1111_1111, 5);
    checkValue("busy_before_reset", 32'(busyV[0]), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkReset(0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    pushExp(0, 32'h0000_000C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, ALU_ADD, 32'h0000_0005, 32'h0000_0007, 8);
    waitIdle();

    // Width sweep: random ops against the model, plus fixed corner cases.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 12; n++) begin
        rop = opList[$urandom_range(0, 9)];
        ra  = $urandom;
        rb  = $urandom;
        if (n == 0) begin rop = ALU_SUB; rb = ra; end
        if (n == 1) begin rop = ALU_SLT; ra = 32'h8000_0000; rb = 32'h0000_0001; end
        if (n == 2) begin rop = ALU_ANDN; ra = 32'hFF00_FF00; rb = 32'h0F0F_0F0F; end
        if (n == 3) begin rop = ALU_SLTU; ra = 32'h0000_0001; rb = 32'hFFFF_FFFF; end
        e = refModel(i, rop, ra, rb);
        sbQ.push_back(e);
        applyStimulus(i, rop, ra, rb, XLEN / dwOf(i));
      end
      waitIdle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
